pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 18 +
 rtl/pc_sequencer_ret_stack.sv | 64 ++++++
 rtl/pc_sequencer.sv | 109 ++++++++++
 tb/tb_pc_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared processor definitions for the program-counter sequencer:
// op encodings and a sizing helper for the return-stack pointer.
package pc_sequencer_pkg;

  // Operation encodings; codes 3'd6 and 3'd7 are reserved and behave as HOLD.
  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_INC  = 3'd1;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;

  // Width needed to count 0..depth inclusive.
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// LIFO return-address stack. The caller guarantees push only when not
// full and pop only when not empty. Storage is deliberately not reset:
// with count at zero, stale entries can never be read out through top.
module pc_ret_stack
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  logic                                pop,
  input  logic [WIDTH-1:0]                    push_data,
  output logic [WIDTH-1:0]                    top,
  output logic [$clog2(DEPTH+1)-1:0]          count
);

  localparam int CW = sp_width(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [CW-1:0]    count_r;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    rd_idx_s;

  // Write slot is the current count; the newest entry sits one below it.
  always_comb begin
    wr_idx_s = AW'(count_r);
    rd_idx_s = AW'(count_r - CW'(1));
  end

  // Occupancy counter, cleared asynchronously; push wins if both ever assert.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (push) begin
      count_r <= count_r + CW'(1);
    end else if (pop) begin
      count_r <= count_r - CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Entry storage, no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_idx_s] <= push_data;
    end
  end

  // Newest entry; forced to zero when empty so no stale value leaks out.
  always_comb begin
    if (count_r == CW'(0)) begin
      top = {WIDTH{1'b0}};
    end else begin
      top = mem_r[rd_idx_s];
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC and a sticky stack-fault flag,
// decodes HOLD/INC/JMP/BR/CALL/RET and drives the return stack.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                WIDTH        = 4,
  parameter int                DEPTH        = 4,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic [2:0]                  op,
  input  logic [WIDTH-1:0]            target,
  input  logic [WIDTH-1:0]            offset,
  output logic [WIDTH-1:0]            pc_out,
  output logic [$clog2(DEPTH+1)-1:0]  sp,
  output logic                        stack_full,
  output logic                        stack_empty,
  output logic                        fault
);

  localparam int CW = sp_width(DEPTH);

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_next_s;
  logic             fault_r;
  logic             fault_next_s;
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] ret_addr_s;
  logic [WIDTH-1:0] top_s;
  logic [CW-1:0]    count_s;
  logic             full_s;
  logic             empty_s;

  assign ret_addr_s = pc_r + WIDTH'(1);
  assign full_s     = (count_s == CW'(DEPTH));
  assign empty_s    = (count_s == CW'(0));

  pc_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (ret_addr_s),
    .top       (top_s),
    .count     (count_s)
  );

  // Op decode: next PC, fault update and stack control; stall overrides all.
  always_comb begin
    pc_next_s    = pc_r;
    fault_next_s = fault_r;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    if (stall) begin
      pc_next_s    = pc_r;
      fault_next_s = fault_r;
    end else begin
      case (op)
        OP_HOLD: pc_next_s = pc_r;
        OP_INC:  pc_next_s = pc_r + WIDTH'(1);
        OP_JMP:  pc_next_s = target;
        // Offset is already WIDTH bits, so a plain modular add equals
        // adding the sign-extended displacement.
        OP_BR:   pc_next_s = pc_r + offset;
        OP_CALL: begin
          if (full_s) begin
            fault_next_s = 1'b1;
          end else begin
            push_s    = 1'b1;
            pc_next_s = target;
          end
        end
        OP_RET: begin
          if (empty_s) begin
            fault_next_s = 1'b1;
          end else begin
            pop_s     = 1'b1;
            pc_next_s = top_s;
          end
        end
        default: pc_next_s = pc_r;
      endcase
    end
  end

  // PC and sticky fault registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r    <= RESET_VECTOR;
      fault_r <= 1'b0;
    end else begin
      pc_r    <= pc_next_s;
      fault_r <= fault_next_s;
    end
  end

  assign pc_out      = pc_r;
  assign fault       = fault_r;
  assign sp          = count_s;
  assign stack_full  = full_s;
  assign stack_empty = empty_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (WIDTH=4, DEPTH=2, RESET_VECTOR=0):
// a directed vector table, a mid-cycle reset sequence, and randomized ops
// checked against a queue-based reference model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int W = 4;
  localparam int D = 2;

  logic       clk;
  logic       reset;
  logic       stall;
  logic [2:0] op;
  logic [3:0] target;
  logic [3:0] offset;
  logic [3:0] pc_out;
  logic [1:0] sp;
  logic       stack_full;
  logic       stack_empty;
  logic       fault;

  int checks;
  int errors;

  pc_sequencer #(.WIDTH(W), .DEPTH(D), .RESET_VECTOR(4'd0)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .op          (op),
    .target      (target),
    .offset      (offset),
    .pc_out      (pc_out),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic [2:0] op;
    logic [3:0] target;
    logic [3:0] offset;
    int         exp_pc;
    int         exp_sp;
    int         exp_fault;
  } vec_t;

  vec_t vecs[$];

  // reference model state
  int m_pc;
  int m_fault;
  int m_stack[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e_pc, input int e_sp, input int e_fault);
    check({tag, " pc"},    int'(pc_out), e_pc);
    check({tag, " sp"},    int'(sp), e_sp);
    check({tag, " fault"}, int'(fault), e_fault);
    check({tag, " full"},  int'(stack_full), int'(e_sp == D));
    check({tag, " empty"}, int'(stack_empty), int'(e_sp == 0));
  endtask

  task automatic add(input logic s, input logic [2:0] o, input logic [3:0] t,
                     input logic [3:0] f, input int p, input int q, input int flt);
    vec_t v;
    v.stall = s; v.op = o; v.target = t; v.offset = f;
    v.exp_pc = p; v.exp_sp = q; v.exp_fault = flt;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic s, input logic [2:0] o, input logic [3:0] t, input logic [3:0] f);
    stall = s; op = o; target = t; offset = f;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_fault = 0;
    m_stack.delete();
  endtask

  // Behavioural rules: modular PC arithmetic and a bounded LIFO queue.
  task automatic model_step(input logic s, input logic [2:0] o, input int t, input int f);
    int sx;
    if (s) return;
    case (o)
      3'd1: m_pc = (m_pc + 1) % 16;
      3'd2: m_pc = t;
      3'd3: begin
        sx = (f >= 8) ? f - 16 : f;
        m_pc = (m_pc + sx + 16) % 16;
      end
      3'd4: begin
        if (m_stack.size() < D) begin
          m_stack.push_back((m_pc + 1) % 16);
          m_pc = t;
        end else begin
          m_fault = 1;
        end
      end
      3'd5: begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else m_fault = 1;
      end
      default: ;
    endcase
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; stall = 1'b0; op = OP_HOLD; target = 4'd0; offset = 4'd0;

    // reset state, before any clock edge
    #2;
    check_all("reset", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // directed vectors from reset
    for (int i = 0; i < 17; i++) add(1'b0, OP_INC, 4'd0, 4'd0, (i + 1) % 16, 0, 0);
    add(1'b0, OP_INC,  4'd0,  4'd0, 2, 0, 0);
    add(1'b0, OP_INC,  4'd0,  4'd0, 3, 0, 0);
    add(1'b0, OP_BR,   4'd0,  4'hE, 1, 0, 0);
    add(1'b0, OP_JMP,  4'd14, 4'd0, 14, 0, 0);
    add(1'b0, OP_BR,   4'd0,  4'd3, 1, 0, 0);
    add(1'b0, OP_JMP,  4'd2,  4'd0, 2, 0, 0);
    add(1'b0, OP_CALL, 4'd9,  4'd0, 9, 1, 0);   // pushes 3
    add(1'b0, OP_CALL, 4'd12, 4'd0, 12, 2, 0);  // pushes 10
    add(1'b0, OP_CALL, 4'd5,  4'd0, 12, 2, 1);  // overflow
    add(1'b0, OP_RET,  4'd0,  4'd0, 10, 1, 1);
    add(1'b0, OP_RET,  4'd0,  4'd0, 3, 0, 1);
    add(1'b0, OP_RET,  4'd0,  4'd0, 3, 0, 1);   // underflow
    add(1'b0, OP_JMP,  4'd4,  4'd0, 4, 0, 1);
    add(1'b0, OP_CALL, 4'd5,  4'd0, 5, 1, 1);   // pushes 5
    for (int i = 0; i < 3; i++) add(1'b1, OP_JMP, 4'd7, 4'd0, 5, 1, 1);
    add(1'b0, OP_JMP,  4'd7,  4'd0, 7, 1, 1);
    add(1'b0, OP_HOLD, 4'd3,  4'd2, 7, 1, 1);
    add(1'b0, 3'd6,    4'd1,  4'd1, 7, 1, 1);
    add(1'b0, 3'd7,    4'd1,  4'd1, 7, 1, 1);
    add(1'b1, OP_RET,  4'd0,  4'd0, 7, 1, 1);
    add(1'b0, OP_RET,  4'd0,  4'd0, 5, 0, 1);
    add(1'b0, OP_CALL, 4'd1,  4'd0, 1, 1, 1);
    add(1'b0, OP_CALL, 4'd2,  4'd0, 2, 2, 1);

    foreach (vecs[i]) begin
      apply(vecs[i].stall, vecs[i].op, vecs[i].target, vecs[i].offset);
      check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_sp, vecs[i].exp_fault);
    end

    // asynchronous reset between edges with fault=1, sp=2
    stall = 1'b0; op = OP_HOLD;
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    apply(1'b0, OP_RET, 4'd0, 4'd0);
    check_all("ret_after_reset", 0, 0, 1);

    // randomized ops against the reference model
    reset = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic       s;
      logic [2:0] o;
      logic [3:0] t;
      logic [3:0] f;
      if ($urandom_range(0, 59) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all($sformatf("rnd_reset%0d", n), m_pc, m_stack.size(), m_fault);
        @(negedge clk);
        reset = 1'b0;
      end
      s = ($urandom_range(0, 4) == 0);
      o = 3'($urandom_range(0, 7));
      t = 4'($urandom_range(0, 15));
      f = 4'($urandom_range(0, 15));
      apply(s, o, t, f);
      model_step(s, o, int'(t), int'(f));
      check_all($sformatf("rnd%0d", n), m_pc, m_stack.size(), m_fault);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
